// File: rtl/sha2_pkg.sv
// Shared SHA-2 message-schedule constants: round counts, sigma rotate/shift
// amounts for SHA-256 and SHA-512, and the schedule generator state type.
package sha2_pkg;

    localparam int ROUNDS_256 = 64;
    localparam int ROUNDS_512 = 80;

    // sigma0 = ROTR(a) ^ ROTR(b) ^ SHR(s)
    localparam int S0_ROT_A_32 = 7;
    localparam int S0_ROT_B_32 = 18;
    localparam int S0_SHR_32   = 3;
    localparam int S1_ROT_A_32 = 17;
    localparam int S1_ROT_B_32 = 19;
    localparam int S1_SHR_32   = 10;

    localparam int S0_ROT_A_64 = 1;
    localparam int S0_ROT_B_64 = 8;
    localparam int S0_SHR_64   = 7;
    localparam int S1_ROT_A_64 = 19;
    localparam int S1_ROT_B_64 = 61;
    localparam int S1_SHR_64   = 6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    function automatic int rounds_for(input int word_w);
        return (word_w == 64) ? ROUNDS_512 : ROUNDS_256;
    endfunction

endpackage

// File: rtl/sha2_sigma.sv
// Combinational SHA-2 small sigma: sel=0 gives sigma0, sel=1 gives sigma1.
module sha2_sigma
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              sel,
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y
);

    localparam int R0A = (WORD_W == 64) ? S0_ROT_A_64 : S0_ROT_A_32;
    localparam int R0B = (WORD_W == 64) ? S0_ROT_B_64 : S0_ROT_B_32;
    localparam int H0  = (WORD_W == 64) ? S0_SHR_64   : S0_SHR_32;
    localparam int R1A = (WORD_W == 64) ? S1_ROT_A_64 : S1_ROT_A_32;
    localparam int R1B = (WORD_W == 64) ? S1_ROT_B_64 : S1_ROT_B_32;
    localparam int H1  = (WORD_W == 64) ? S1_SHR_64   : S1_SHR_32;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] v, input int r);
        return (v >> r) | (v << (WORD_W - r));
    endfunction

    always_comb begin
        y = '0;
        if (sel)
            y = rotr(x, R1A) ^ rotr(x, R1B) ^ (x >> H1);
        else
            y = rotr(x, R0A) ^ rotr(x, R0B) ^ (x >> H0);
    end

endmodule

// File: rtl/sha2_schedule_gen.sv
// SHA-2 message schedule generator: loads a 16-word block and streams
// W_0..W_{ROUNDS-1} with valid/ready flow control, one word per cycle.
module sha2_schedule_gen
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   blk_valid,
    output logic                   blk_ready,
    input  logic [16*WORD_W-1:0]   blk_data,
    output logic                   w_valid,
    input  logic                   w_ready,
    output logic [WORD_W-1:0]      w_data,
    output logic [6:0]             w_index,
    output logic                   w_last,
    input  logic                   abort
);

    localparam int ROUNDS = rounds_for(WORD_W);
    localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);

    sched_state_t state_q, state_d;
    logic [15:0][WORD_W-1:0] window;
    logic [6:0]              idx_q;
    logic [WORD_W-1:0]       s0, s1, w_new;
    logic                    load, hs;

    sha2_sigma #(.WORD_W(WORD_W)) u_sigma0 (.sel(1'b0), .x(window[1]),  .y(s0));
    sha2_sigma #(.WORD_W(WORD_W)) u_sigma1 (.sel(1'b1), .x(window[14]), .y(s1));

    assign w_new     = s1 + window[9] + s0 + window[0];
    assign blk_ready = (state_q == ST_IDLE);
    assign w_valid   = (state_q == ST_RUN);
    assign w_data    = window[0];
    assign w_index   = idx_q;
    assign w_last    = w_valid && (idx_q == LAST_IDX);
    assign load      = blk_ready && blk_valid;
    assign hs        = w_valid && w_ready && !abort;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (load) state_d = ST_RUN;
            ST_RUN: begin
                // abort wins over a coincident handshake
                if (abort)            state_d = ST_IDLE;
                else if (hs && w_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            window  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                // M0 sits in the top bits of blk_data and becomes window[0]
                for (int i = 0; i < 16; i++)
                    window[i] <= blk_data[(15-i)*WORD_W +: WORD_W];
                idx_q <= '0;
            end else if (hs) begin
                window <= {w_new, window[15:1]};
                idx_q  <= idx_q + 7'd1;
            end
        end
    end

endmodule

// File: tb/tb_sha2_schedule_gen.sv
// Directed bench for sha2_schedule_gen: SHA-256 "hello" block, SHA-512 zero
// block, backpressure, abort, mid-run reset and blk_valid during RUN.
module tb_sha2_schedule_gen;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 32-bit instance
    logic         bv32, br32, wv32, wr32, wl32, ab32;
    logic [511:0] bd32;
    logic [31:0]  wd32;
    logic [6:0]   wi32;

    // 64-bit instance
    logic          bv64, br64, wv64, wr64, wl64, ab64;
    logic [1023:0] bd64;
    logic [63:0]   wd64;
    logic [6:0]    wi64;

    sha2_schedule_gen #(.WORD_W(32)) dut32 (
        .clk(clk), .reset(reset), .blk_valid(bv32), .blk_ready(br32),
        .blk_data(bd32), .w_valid(wv32), .w_ready(wr32), .w_data(wd32),
        .w_index(wi32), .w_last(wl32), .abort(ab32)
    );

    sha2_schedule_gen #(.WORD_W(64)) dut64 (
        .clk(clk), .reset(reset), .blk_valid(bv64), .blk_ready(br64),
        .blk_data(bd64), .w_valid(wv64), .w_ready(wr64), .w_data(wd64),
        .w_index(wi64), .w_last(wl64), .abort(ab64)
    );

    int checks = 0;
    int errors = 0;

    localparam logic [511:0] HELLO = {32'h68656c6c, 32'h6f800000, 416'h0, 32'h00000028};
    localparam logic [31:0]  W16   = 32'h7594884C;
    localparam logic [31:0]  W17   = 32'h6F910000;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a block for one cycle; returns at the negedge after the load edge.
    task automatic load32(input logic [511:0] d, input logic ab);
        bv32 = 1'b1; bd32 = d; ab32 = ab;
        @(negedge clk);
        bv32 = 1'b0; ab32 = 1'b0;
    endtask

    // Advance (w_ready high) until w_index == idx with w_valid, bounded.
    task automatic run_to32(input int idx);
        int n = 0;
        wr32 = 1'b1;
        while (!(wv32 && wi32 == 7'(idx)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("reach_idx_%0d", idx), {57'd0, wi32}, 64'(idx));
    endtask

    // Drain the rest of a block; report the last index seen with w_last.
    task automatic drain32(output int last_idx);
        int n = 0;
        last_idx = -1;
        wr32 = 1'b1;
        while (wv32 && n < 200) begin
            if (wl32) last_idx = int'(wi32);
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int cnt, last_idx, bad_last, bad_idx, nonzero;

        reset = 1'b1;
        bv32 = 0; wr32 = 0; ab32 = 0; bd32 = '0;
        bv64 = 0; wr64 = 0; ab64 = 0; bd64 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // reset state
        chk("rst_blk_ready", 64'(br32), 64'd1);
        chk("rst_w_valid",   64'(wv32), 64'd0);
        chk("rst_w_data",    64'(wd32), 64'd0);
        chk("rst_w_index",   64'(wi32), 64'd0);
        chk("rst_w_last",    64'(wl32), 64'd0);
        chk("rst_w_data64",  wd64,      64'd0);

        // SHA-256 "hello", w_ready held high
        wr32 = 1'b1;
        load32(HELLO, 1'b0);
        cnt = 0; bad_last = 0; bad_idx = 0; last_idx = -1;
        for (int n = 0; n < 100 && wv32; n++) begin
            if (wi32 !== 7'(cnt)) bad_idx++;
            if (wl32 !== (cnt == 63)) bad_last++;
            if (cnt == 0)  chk("hello_w0",  64'(wd32), 64'h68656c6c);
            if (cnt == 15) chk("hello_w15", 64'(wd32), 64'h00000028);
            if (cnt == 16) chk("hello_w16", 64'(wd32), 64'(W16));
            if (cnt == 17) chk("hello_w17", 64'(wd32), 64'(W17));
            if (cnt == 0)  chk("hello_busy", 64'(br32), 64'd0);
            cnt++;
            @(negedge clk);
        end
        chk("hello_count",    64'(cnt),      64'd64);
        chk("hello_idx_seq",  64'(bad_idx),  64'd0);
        chk("hello_last_pos", 64'(bad_last), 64'd0);
        chk("hello_idle_rdy", 64'(br32),     64'd1);

        // SHA-512 all-zero block
        wr64 = 1'b1; bv64 = 1'b1; bd64 = '0;
        @(negedge clk);
        bv64 = 1'b0;
        cnt = 0; nonzero = 0; last_idx = -1; bad_last = 0;
        for (int n = 0; n < 120 && wv64; n++) begin
            if (wd64 !== 64'd0) nonzero++;
            if (wl64) begin
                if (last_idx != -1) bad_last++;
                last_idx = int'(wi64);
            end
            cnt++;
            @(negedge clk);
        end
        chk("z512_count",    64'(cnt),      64'd80);
        chk("z512_nonzero",  64'(nonzero),  64'd0);
        chk("z512_last_idx", 64'(last_idx), 64'd79);
        chk("z512_last_once",64'(bad_last), 64'd0);
        chk("z512_rdy_after",64'(br64),     64'd1);
        chk("z512_vld_after",64'(wv64),     64'd0);

        // backpressure at index 16
        load32(HELLO, 1'b0);
        run_to32(16);
        wr32 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_data", 64'(wd32), 64'(W16));
            chk("bp_idx",  64'(wi32), 64'd16);
            chk("bp_vld",  64'(wv32), 64'd1);
        end
        wr32 = 1'b1;
        @(negedge clk);
        chk("bp_resume_idx",  64'(wi32), 64'd17);
        chk("bp_resume_data", 64'(wd32), 64'(W17));
        drain32(last_idx);
        chk("bp_last_idx", 64'(last_idx), 64'd63);

        // abort at index 20, then reload with a coincident (ignored) abort
        load32(HELLO, 1'b0);
        run_to32(20);
        ab32 = 1'b1;
        @(negedge clk);
        ab32 = 1'b0;
        chk("abort_vld", 64'(wv32), 64'd0);
        chk("abort_rdy", 64'(br32), 64'd1);
        load32(HELLO, 1'b1);
        chk("reload_vld", 64'(wv32), 64'd1);
        chk("reload_idx", 64'(wi32), 64'd0);
        chk("reload_w0",  64'(wd32), 64'h68656c6c);
        run_to32(16);
        chk("reload_w16", 64'(wd32), 64'(W16));
        drain32(last_idx);
        chk("reload_last_idx", 64'(last_idx), 64'd63);

        // reset at index 30
        load32(HELLO, 1'b0);
        run_to32(30);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_vld",  64'(wv32), 64'd0);
        chk("mrst_data", 64'(wd32), 64'd0);
        chk("mrst_idx",  64'(wi32), 64'd0);
        chk("mrst_last", 64'(wl32), 64'd0);
        @(negedge clk);
        chk("mrst_rdy",  64'(br32), 64'd1);

        // blk_valid during RUN must not disturb the running block
        load32(HELLO, 1'b0);
        run_to32(5);
        bv32 = 1'b1; bd32 = {512{1'b1}};
        run_to32(16);
        chk("run_blk_rdy", 64'(br32), 64'd0);
        chk("run_blk_w16", 64'(wd32), 64'(W16));
        @(negedge clk);
        chk("run_blk_w17", 64'(wd32), 64'(W17));
        bv32 = 1'b0;
        drain32(last_idx);
        chk("run_blk_last", 64'(last_idx), 64'd63);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
